// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-requester memory arbiter: the arbiter FSM state
// encoding and the requester index type used for grants and last_gnt.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   // LOCKn: requester n currently owns the memory port under a lock.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   // Requester index: 0 = core (m0), 1 = loader/debug (m1).
   typedef logic req_idx_t;

   localparam req_idx_t IDX_M0 = 1'b0;
   localparam req_idx_t IDX_M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Two-input round-robin picker. On a conflict the requester that was NOT
// granted last wins; a lone requester always wins.
// Ports:
//   i_req0, i_req1 : request lines of requester 0 / 1
//   i_last_gnt     : index of the most recently granted requester
//   o_valid        : some requester is picked
//   o_idx          : picked requester index (meaningful when o_valid=1)
// -----------------------------------------------------------------------------
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic     i_req0,
   input  logic     i_req1,
   input  req_idx_t i_last_gnt,
   output logic     o_valid,
   output req_idx_t o_idx
);

   // Round-robin selection between the two request lines.
   always_comb begin
      o_valid = i_req0 | i_req1;
      o_idx   = IDX_M0;
      if (i_req0 && i_req1) begin
         o_idx = ~i_last_gnt;
      end else if (i_req1) begin
         o_idx = IDX_M1;
      end else begin
         o_idx = IDX_M0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-port memory between the core (m0) and a loader/debug
// master (m1). Round-robin on conflicts, with an optional bounded lock that
// lets one requester keep the port for up to MAX_LOCK consecutive grants.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   mX_req/we/lock          : request, write, lock-hold from requester X
//   mX_adr/wdata            : address and write data from requester X
//   mX_gnt                  : requester X owns the port this cycle (comb.)
//   mX_rvalid               : read data for X valid (cycle after its read)
//   m_rdata                 : shared read data (pass-through of mem_rdata)
//   mem_we/adr/wdata        : memory command from the granted requester
//   mem_rdata               : memory read data, one cycle after the address
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_LOCK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m_rdata,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int            CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

   arb_state_t    r_state,    w_state_nxt;
   req_idx_t      r_last_gnt, w_last_gnt_nxt;
   logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt;
   logic          r_rvalid0,  r_rvalid1;

   logic          w_rr_valid;
   req_idx_t      w_rr_idx;
   logic          w_hold0,    w_hold1;
   logic          w_gnt0,     w_gnt1;
   req_idx_t      w_gnt_idx;
   logic          w_gnt_lock;

   rr_pick u_rr_pick (
      .i_req0     (m0_req),
      .i_req1     (m1_req),
      .i_last_gnt (r_last_gnt),
      .o_valid    (w_rr_valid),
      .o_idx      (w_rr_idx)
   );

   // Grant decision: an unexpired lock owner wins outright, else round-robin.
   always_comb begin
      w_hold0 = (r_state == LOCK0) && m0_req && m0_lock && (r_lock_cnt < CNT_MAX);
      w_hold1 = (r_state == LOCK1) && m1_req && m1_lock && (r_lock_cnt < CNT_MAX);
      w_gnt0  = 1'b0;
      w_gnt1  = 1'b0;
      if (reset) begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end else if (w_hold0) begin
         w_gnt0 = 1'b1;
      end else if (w_hold1) begin
         w_gnt1 = 1'b1;
      end else if (w_rr_valid) begin
         w_gnt0 = (w_rr_idx == IDX_M0);
         w_gnt1 = (w_rr_idx == IDX_M1);
      end else begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
   end

   // Next state, last_gnt and lock counter.
   // The counter includes the current locked grant, so a fresh owner starts
   // at 1 and is allowed exactly MAX_LOCK locked grants before expiry.
   always_comb begin
      w_gnt_idx      = w_gnt1 ? IDX_M1 : IDX_M0;
      w_gnt_lock     = w_gnt1 ? m1_lock : m0_lock;
      w_state_nxt    = IDLE;
      w_last_gnt_nxt = r_last_gnt;
      w_lock_cnt_nxt = '0;
      if (w_gnt0 || w_gnt1) begin
         w_last_gnt_nxt = w_gnt_idx;
         if (w_gnt_lock) begin
            w_state_nxt = (w_gnt_idx == IDX_M1) ? LOCK1 : LOCK0;
            if (r_state == w_state_nxt) begin
               w_lock_cnt_nxt = (r_lock_cnt == CNT_MAX) ? CNT_MAX : r_lock_cnt + CW'(1);
            end else begin
               w_lock_cnt_nxt = CW'(1);
            end
         end else begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
         end
      end else begin
         w_state_nxt    = IDLE;
         w_lock_cnt_nxt = '0;
      end
   end

   // State, arbitration history and read-response tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last_gnt <= IDX_M1;
         r_lock_cnt <= '0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_rvalid0  <= w_gnt0 & ~m0_we;
         r_rvalid1  <= w_gnt1 & ~m1_we;
      end
   end

   // Memory command mux; all-zero when nobody is granted.
   always_comb begin
      if (w_gnt0) begin
         mem_we    = m0_we;
         mem_adr   = m0_adr;
         mem_wdata = m0_wdata;
      end else if (w_gnt1) begin
         mem_we    = m1_we;
         mem_adr   = m1_adr;
         mem_wdata = m1_wdata;
      end else begin
         mem_we    = 1'b0;
         mem_adr   = 32'd0;
         mem_wdata = 32'd0;
      end
   end

   // A response pending from the cycle before reset is suppressed during reset.
   assign m0_rvalid = r_rvalid0 & ~reset;
   assign m1_rvalid = r_rvalid1 & ~reset;
   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MAX_LOCK = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m_rdata;
   logic        mem_we;
   logic [31:0] mem_adr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;

   // Stimulus held per requester
   bit          r[2];
   bit          lk[2];
   bit          we[2];
   logic [31:0] adr[2];
   logic [31:0] wd[2];

   assign m0_req = r[0];  assign m0_lock = lk[0]; assign m0_we = we[0];
   assign m0_adr = adr[0]; assign m0_wdata = wd[0];
   assign m1_req = r[1];  assign m1_lock = lk[1]; assign m1_we = we[1];
   assign m1_adr = adr[1]; assign m1_wdata = wd[1];

   mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
      .m0_adr(m0_adr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
      .m1_adr(m1_adr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m_rdata(m_rdata),
      .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: a read of address A returns (A>>2)+1 on the following cycle.
   always @(posedge clk) begin
      if ((m0_gnt || m1_gnt) && !mem_we) mem_rdata <= (mem_adr >> 2) + 32'd1;
      else                               mem_rdata <= 32'hBAD0_0000;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model: current lock owner (-1 none), locked grants so far,
   // last granted requester, and the read awaiting its response.
   int          own  = -1;
   int          run  = 0;
   int          last = 1;
   bit          pend_v = 1'b0;
   int          pend_i = 0;
   logic [31:0] pend_a = 32'd0;

   // Observations from the most recent step, for scenario-specific checks.
   logic        o_g0, o_g1, o_rv0, o_rv1, o_we;
   logic [31:0] o_adr, o_wdata, o_rdata;

   function automatic int exp_gnt();
      if (own >= 0 && r[own] && lk[own] && run < MAX_LOCK) return own;
      if (r[0] && r[1]) return 1 - last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
   endfunction

   // One clock cycle: check outputs mid-cycle, then advance the model.
   task automatic step(input bit rst);
      int g;
      int gi;
      reset = rst;
      @(negedge clk);
      g  = rst ? -1 : exp_gnt();
      gi = (g >= 0) ? g : 0;
      o_g0 = m0_gnt; o_g1 = m1_gnt; o_rv0 = m0_rvalid; o_rv1 = m1_rvalid;
      o_we = mem_we; o_adr = mem_adr; o_wdata = mem_wdata; o_rdata = m_rdata;
      chk("m0_gnt",    32'(m0_gnt),    32'(g == 0));
      chk("m1_gnt",    32'(m1_gnt),    32'(g == 1));
      chk("mem_we",    32'(mem_we),    (g >= 0) ? 32'(we[gi]) : 32'd0);
      chk("mem_adr",   mem_adr,        (g >= 0) ? adr[gi] : 32'd0);
      chk("mem_wdata", mem_wdata,      (g >= 0) ? wd[gi]  : 32'd0);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(!rst && pend_v && pend_i == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(!rst && pend_v && pend_i == 1));
      if (!rst && pend_v) chk("m_rdata", m_rdata, (pend_a >> 2) + 32'd1);
      @(posedge clk);
      #1;
      if (rst) begin
         own = -1; run = 0; last = 1; pend_v = 1'b0;
      end else begin
         pend_v = (g >= 0) && !we[gi];
         pend_i = gi;
         pend_a = adr[gi];
         if (g < 0) begin
            own = -1; run = 0;
         end else begin
            last = g;
            if (lk[g]) begin
               run = (own == g) ? ((run < MAX_LOCK) ? run + 1 : MAX_LOCK) : 1;
               own = g;
            end else begin
               own = -1; run = 0;
            end
         end
      end
   endtask

   task automatic clear_in();
      for (int i = 0; i < 2; i++) begin
         r[i] = 1'b0; lk[i] = 1'b0; we[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
      end
   endtask

   initial begin
      int g0_cnt;
      clear_in();
      reset = 1'b1;

      // Reset: nothing granted, no write, no response
      step(1'b1);
      step(1'b1);
      chk("rst_gnt0", 32'(o_g0), 32'd0);
      chk("rst_we",   32'(o_we), 32'd0);

      // Conflict right after reset: core first, then loader
      r[0] = 1'b1; adr[0] = 32'h10;
      r[1] = 1'b1; adr[1] = 32'h20;
      step(1'b0);
      chk("conf_g0",  32'(o_g0), 32'd1);
      chk("conf_adr", o_adr, 32'h10);
      step(1'b0);
      chk("conf_g1",  32'(o_g1),  32'd1);
      chk("conf_adr2", o_adr,     32'h20);
      chk("conf_rv0", 32'(o_rv0), 32'd1);
      chk("conf_rd0", o_rdata,    32'h5);
      clear_in();
      step(1'b0);
      chk("conf_rv1", 32'(o_rv1), 32'd1);

      // Uncontended write from m1
      r[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; wd[1] = 32'hDEAD_BEEF;
      step(1'b0);
      chk("wr_we",    32'(o_we), 32'd1);
      chk("wr_wdata", o_wdata,   32'hDEAD_BEEF);
      clear_in();
      step(1'b0);
      chk("wr_norv",  32'(o_rv1), 32'd0);

      // Lock expiry: m0 holds lock, m1 keeps asking
      r[0] = 1'b1; lk[0] = 1'b1; adr[0] = 32'h100;
      r[1] = 1'b1; adr[1] = 32'h200;
      g0_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0);
         if (o_g0) g0_cnt++;
      end
      chk("lock_g0_cnt", 32'(g0_cnt), 32'd4);
      step(1'b0);
      chk("lock_exp_g1", 32'(o_g1), 32'd1);
      // Count restarted: m0 reacquires and is held again
      step(1'b0);
      chk("lock_reacq", 32'(o_g0), 32'd1);
      step(1'b0);
      chk("lock_hold", 32'(o_g0), 32'd1);

      // Release: owner drops req mid-lock, m1 granted same cycle
      r[0] = 1'b0;
      step(1'b0);
      chk("rel_g1", 32'(o_g1), 32'd1);
      clear_in();
      step(1'b0);

      // Back-to-back reads from m0
      r[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adr[0] = 32'(4 * i);
         step(1'b0);
         if (i > 0) chk("b2b_rd", o_rdata, 32'(i));
      end
      clear_in();
      step(1'b0);
      chk("b2b_rv3", 32'(o_rv0), 32'd1);
      chk("b2b_rd3", o_rdata,    32'd3);
      step(1'b0);
      chk("b2b_end", 32'(o_rv0), 32'd0);

      // Reset the cycle after an m1 read grant
      r[1] = 1'b1; adr[1] = 32'h80;
      step(1'b0);
      chk("rm_g1", 32'(o_g1), 32'd1);
      step(1'b1);
      chk("rm_rv1", 32'(o_rv1), 32'd0);
      chk("rm_g1r", 32'(o_g1),  32'd0);
      r[0] = 1'b1; adr[0] = 32'h84;
      step(1'b0);
      chk("rm_idle_g0", 32'(o_g0), 32'd1);
      step(1'b0);
      chk("rm_norv1", 32'(o_rv1), 32'd0);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            r[i]   = ($urandom_range(0, 3) != 0);
            lk[i]  = ($urandom_range(0, 2) != 0);
            we[i]  = $urandom_range(0, 1) != 0;
            adr[i] = $urandom & 32'h0000_FFFC;
            wd[i]  = $urandom;
         end
         step($urandom_range(0, 63) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
